// File: rtl/ba_lock_fsm.sv
// ba_lock_fsm: 128b/130b block alignment FSM: EIEOS search, sync-header decode, counter control and symbol assembly
module ba_lock_fsm #(
    parameter int SYMBOL_COUNT_WIDTH = 4,
    parameter int BITS_COUNT_WIDTH   = 3
) (
    input  logic                          rx_clk,
    input  logic                          rx_rst,
    input  logic                          Soft_RST_blocks,
    input  logic                          rx_bit,
    input  logic [BITS_COUNT_WIDTH-1:0]   bits_count,
    input  logic [SYMBOL_COUNT_WIDTH-1:0] symbols_count,
    output logic                          cnt_bits_en,
    output logic                          cnt_symbols_en,
    output logic                          reint_cnt_bits,
    output logic                          reint_cnt_symbols,
    output logic [7:0]                    sym_data,
    output logic                          sym_valid,
    output logic [3:0]                    sym_idx,
    output logic                          blk_type,
    output logic                          blk_start,
    output logic                          block_aligned,
    output logic                          sync_err,
    output logic                          realign
);
    typedef enum logic [1:0] {UNALIGNED, EIEOS_TAIL, SYNC_HDR, PAYLOAD} state_t;
    // Bit 0 is the oldest bit: OS header (1,0) then EIEOS symbols 0..3
    localparam logic [33:0] EIEOS_PAT = {8'hff, 8'h00, 8'hff, 8'h00, 2'b01};
    state_t      state, state_n;
    logic [32:0] hist;
    logic [7:0]  asm_q, asm_n;
    logic [3:0]  idx_n;
    logic        rst, h0, h0_n, sv_n, bt_n, bs_n, se_n, ra_n;
    logic        eieos_hit, exp_hit, last_bit;
    assign rst            = rx_rst | Soft_RST_blocks;
    assign asm_n          = {rx_bit, asm_q[7:1]};
    assign eieos_hit      = {rx_bit, hist} == EIEOS_PAT;
    assign last_bit       = bits_count == BITS_COUNT_WIDTH'(7);
    assign exp_hit        = blk_type && symbols_count == SYMBOL_COUNT_WIDTH'(3) && last_bit;
    assign block_aligned  = state != UNALIGNED;
    assign cnt_symbols_en = 1'b0;
    always_comb begin
        state_n           = state;
        cnt_bits_en       = 1'b1;
        reint_cnt_bits    = 1'b0;
        reint_cnt_symbols = 1'b0;
        h0_n              = h0;
        sv_n              = 1'b0;
        idx_n             = sym_idx;
        bt_n              = blk_type;
        bs_n              = 1'b0;
        se_n              = 1'b0;
        ra_n              = 1'b0;
        case (state)
            UNALIGNED: begin
                reint_cnt_bits    = 1'b1;
                reint_cnt_symbols = 1'b1;
                if (eieos_hit) begin
                    bt_n    = 1'b1;
                    bs_n    = 1'b1;
                    state_n = EIEOS_TAIL;
                end
            end
            EIEOS_TAIL: if (last_bit) begin
                sv_n  = 1'b1;
                idx_n = 4'(symbols_count) + 4'd4;
                if (symbols_count == SYMBOL_COUNT_WIDTH'(11)) begin
                    reint_cnt_symbols = 1'b1;
                    state_n           = SYNC_HDR;
                end
            end
            default: if (eieos_hit && !exp_hit) begin
                reint_cnt_bits    = 1'b1;
                reint_cnt_symbols = 1'b1;
                bt_n              = 1'b1;
                bs_n              = 1'b1;
                ra_n              = 1'b1;
                state_n           = EIEOS_TAIL;
            end else if (state == SYNC_HDR) begin
                if (bits_count == BITS_COUNT_WIDTH'(0)) h0_n = rx_bit;
                else if (bits_count == BITS_COUNT_WIDTH'(1)) begin
                    reint_cnt_bits = 1'b1;
                    // Valid headers differ in their two bits; H0 alone gives the type
                    if (h0 != rx_bit) begin
                        bt_n    = h0;
                        bs_n    = 1'b1;
                        state_n = PAYLOAD;
                    end else begin
                        se_n              = 1'b1;
                        reint_cnt_symbols = 1'b1;
                        state_n           = UNALIGNED;
                    end
                end
            end else if (last_bit) begin
                sv_n  = 1'b1;
                idx_n = 4'(symbols_count);
                if (symbols_count == SYMBOL_COUNT_WIDTH'(15)) begin
                    reint_cnt_symbols = 1'b1;
                    state_n           = SYNC_HDR;
                end
            end
        endcase
    end
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state     <= UNALIGNED;
            hist      <= '0;
            asm_q     <= '0;
            h0        <= 1'b0;
            sym_data  <= '0;
            sym_valid <= 1'b0;
            sym_idx   <= '0;
            blk_type  <= 1'b0;
            blk_start <= 1'b0;
            sync_err  <= 1'b0;
            realign   <= 1'b0;
        end else begin
            state     <= state_n;
            hist      <= {rx_bit, hist[32:1]};
            asm_q     <= asm_n;
            h0        <= h0_n;
            sym_data  <= sv_n ? asm_n : sym_data;
            sym_valid <= sv_n;
            sym_idx   <= idx_n;
            blk_type  <= bt_n;
            blk_start <= bs_n;
            sync_err  <= se_n;
            realign   <= ra_n;
        end
    end
endmodule
